bpsk_frame_modulator: RTL

//  Transmit-side modulator; sits directly upstream of the receiver's AD input.

---
 rtl/bpsk_frame_modulator.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bpsk_frame_modulator.sv
// BPSK frame modulator: guard / LSB-first BPSK payload / guard, one DA sample per clock.
// Outputs are registered from next-state values so each sample lines up with its state.
module bpsk_frame_modulator #(
    parameter int unsigned SPB        = 90,
    parameter int unsigned GUARD      = 720,
    parameter logic [7:0]  IDLE_LEVEL = 8'h7f
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] tx_da,
    output logic       tx_sync_out,
    output logic       busy,
    output logic       underrun
);
    localparam int unsigned GCW = $clog2(GUARD);
    localparam int unsigned SCW = $clog2(SPB);
    localparam logic [GCW-1:0] G_LAST = GCW'(GUARD - 1);
    localparam logic [SCW-1:0] S_LAST = SCW'(SPB - 1);

    typedef enum logic [1:0] {IDLE, LEAD, DATA, TAIL} state_t;

    state_t         state_q, state_d;
    logic [GCW-1:0] gcnt_q, gcnt_d;
    logic [SCW-1:0] samp_q, samp_d;
    logic [2:0]     phase_q, phase_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     sh_q, sh_d;
    logic           sh_last_q, sh_last_d;
    logic [7:0]     hold_q, hold_d;
    logic           hold_last_q, hold_last_d;
    logic           hold_full_q, hold_full_d;
    logic [7:0]     da_q, da_d;
    logic           sync_q, sync_d;
    logic           busy_q, busy_d;
    logic           und_q, und_d;
    logic           drain;
    logic           accept;

    function automatic logic [7:0] bpsk(input logic b, input logic [2:0] ph);
        logic [7:0] v;
        unique case (ph)
            3'd0, 3'd3: v = 8'h7f;
            3'd1, 3'd2: v = b ? 8'h93 : 8'h6d;
            default:    v = b ? 8'h6d : 8'h93;
        endcase
        return v;
    endfunction

    assign accept = in_valid && !hold_full_q;

    always_comb begin
        state_d   = state_q;
        gcnt_d    = gcnt_q;
        samp_d    = samp_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        sh_last_d = sh_last_q;
        drain     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    state_d = LEAD;
                    gcnt_d  = '0;
                    drain   = 1'b1;
                end
            end
            LEAD: begin
                if (gcnt_q == G_LAST) begin
                    state_d = DATA;
                    samp_d  = '0;
                    phase_d = '0;
                    bit_d   = '0;
                end else begin
                    gcnt_d = gcnt_q + GCW'(1);
                end
            end
            DATA: begin
                phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
                if (samp_q == S_LAST) begin
                    samp_d = '0;
                    bit_d  = bit_q + 3'd1;
                    // SPB is a multiple of 6, so phase is already back at 0 here
                    if (bit_q == 3'd7) begin
                        if (!sh_last_q && hold_full_q) begin
                            drain = 1'b1;
                        end else begin
                            state_d = TAIL;
                            gcnt_d  = '0;
                        end
                    end
                end else begin
                    samp_d = samp_q + SCW'(1);
                end
            end
            default: begin
                if (gcnt_q == G_LAST) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q + GCW'(1);
                end
            end
        endcase

        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        if (drain) begin
            sh_d        = hold_q;
            sh_last_d   = hold_last_q;
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = in_data;
            hold_last_d = in_last;
            hold_full_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
        sync_d = (state_d == DATA) || (state_d == LEAD && gcnt_d == G_LAST);
        da_d   = (state_d == DATA) ? bpsk(sh_d[bit_d], phase_d) : IDLE_LEVEL;
        // flags the final sample of a byte that has no successor to hand over to
        und_d  = (state_d == DATA) && (bit_d == 3'd7) && (samp_d == S_LAST)
                 && !sh_last_d && !hold_full_d;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            gcnt_q      <= '0;
            samp_q      <= '0;
            phase_q     <= '0;
            bit_q       <= '0;
            sh_q        <= '0;
            sh_last_q   <= 1'b0;
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            da_q        <= IDLE_LEVEL;
            sync_q      <= 1'b0;
            busy_q      <= 1'b0;
            und_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gcnt_q      <= gcnt_d;
            samp_q      <= samp_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            sh_last_q   <= sh_last_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            da_q        <= da_d;
            sync_q      <= sync_d;
            busy_q      <= busy_d;
            und_q       <= und_d;
        end
    end

    assign in_ready    = !hold_full_q;
    assign tx_da       = da_q;
    assign tx_sync_out = sync_q;
    assign busy        = busy_q;
    assign underrun    = und_q;

endmodule
